hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It is the producer side of the stall/flush interface that the fetch, decode→execute and execute→memory pipeline registers consume. It also drives the forwarding-mux selects and tracks data-memory wait states with a timeout FSM. It keeps saturating stall and flush event counters for performance debug.

## Interface
- `TIMEOUT`, default 64: maximum consecutive data-memory wait cycles before an error is declared (≥2).
- `CNT_W`, default 16: width of the event counters.
- `clk` in 1: clock, rising edge.
- `clr_n` in 1: reset. Asynchronous, active-low.
- `rs_d`, `rt_d` in 5: decode-stage source register numbers.
- `rs_e`, `rt_e` in 5: execute-stage source register numbers.
- `write_reg_e`, `write_reg_m`, `write_reg_w` in 5: destination register per stage.
- `reg_write_e`, `reg_write_m`, `reg_write_w` in 1: the instruction in that stage writes the register file.
- `mem_to_reg_e`, `mem_to_reg_m` in 1: the instruction in that stage is a load.
- `branch_d`, `jump_d`, `pc_src_d` in 1: decode branch, jump, and branch-taken.
- `mem_req_m` in 1: memory stage is accessing data memory.
- `mem_ready` in 1: data memory has completed the access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold the corresponding pipeline register.
- `flush_d`, `flush_e`, `flush_w` out 1: clear the corresponding pipeline register to a bubble.
- `forward_a_e`, `forward_b_e` out 2: ALU operand select. 00 = register file, 01 = writeback result, 10 = memory-stage ALU result.
- `forward_a_d`, `forward_b_d` out 1: branch comparator takes the memory-stage ALU result.
- `mem_err` out 1: sticky memory-timeout flag.
- `stall_count`, `flush_count` out `CNT_W`: saturating event counters.

## Operation
- **Register matching.** Register 0 never matches: every match term requires the stage register to be nonzero.
- **Execute forwarding.** For `forward_a_e`, select 10 if `reg_write_m` and `write_reg_m` equals `rs_e`. Otherwise select 01 if `reg_write_w` and `write_reg_w` equals `rs_e`. Otherwise select 00. Memory stage has priority. `forward_b_e` is identical using `rt_e`.
- **Decode forwarding.** `forward_a_d` = `reg_write_m` and `write_reg_m` equals `rs_d`. `forward_b_d` is the same using `rt_d`.
- **Load-use hazard.** `lw_stall` = `mem_to_reg_e` and `write_reg_e` equals `rs_d` or `rt_d`.
- **Branch hazard.** `br_stall` = `branch_d` and either:
  - `reg_write_e` and `write_reg_e` equals `rs_d` or `rt_d`, or
  - `mem_to_reg_m` and `write_reg_m` equals `rs_d` or `rt_d`.
- **Memory-wait FSM.** States are IDLE, WAIT and ERR. `mem_stall` = `mem_req_m` and not `mem_ready` and state ≠ ERR.
  - IDLE goes to WAIT when `mem_stall`, and loads the wait counter with 1.
  - WAIT goes to IDLE when `mem_ready` or when `mem_req_m` drops. Otherwise the wait counter increments.
  - WAIT goes to ERR when the counter reaches `TIMEOUT` with `mem_ready` still low.
  - ERR is absorbing until reset. `mem_err` = 1 in ERR.
- **Stall outputs.**
  - `stall_m` = `stall_e` = `mem_stall`.
  - `stall_f` = `stall_d` = `lw_stall` or `br_stall` or `mem_stall`.
  - `flush_w` = `mem_stall`: a bubble goes into writeback while memory stage is held.
- **Flush outputs.**
  - `flush_e` = (`lw_stall` or `br_stall`) and not `mem_stall`. `flush_e` is never asserted together with `stall_e`, because the pipeline register gives flush priority over stall.
  - `flush_d` = (`pc_src_d` or `jump_d`) and not `stall_d`.
- **Counters.**
  - `stall_count` increments on every cycle `stall_f` is high.
  - `flush_count` increments on every cycle `flush_d` or `flush_e` is high; both high counts +1.
  - Both saturate at 2^`CNT_W` − 1 and do not wrap.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and current FSM state, valid in the same cycle.
- The FSM state, wait counter, `mem_err` and event counters update on the rising edge of `clk`.
- Reset (`clr_n` low, asynchronous) forces:
  - FSM to IDLE and wait counter to 0;
  - `mem_err` to 0 and both event counters to 0.

  Combinational outputs then follow their inputs using IDLE.
- Reset mid-WAIT returns to IDLE at once. If the request is still unready, the next rising edge re-enters WAIT with counter 1.
- A request with `mem_ready` high in the same cycle causes no stall and no state change.
- With `TIMEOUT`=T, an unready request stalls exactly T cycles. `mem_err` rises after the T-th stalled edge. In ERR all stalls from memory are released.
- Simultaneous `lw_stall` and `mem_stall`: all of F, D, E, M are held, with `flush_e`=0 and `flush_w`=1.

## Test plan
- **Load-use.** `mem_to_reg_e`=1, `write_reg_e`=5, `rs_d`=5 → `stall_f`=`stall_d`=1, `flush_e`=1, `stall_e`=0; `stall_count` 0→1 after the edge.
- **Execute forwarding priority.** `rs_e`=7, `write_reg_m`=`write_reg_w`=7, both with `reg_write` set → `forward_a_e`=10. Clear `reg_write_m` → 01. Set `rs_e`=0 with matching writers → 00.
- **Branch hazard and flush.** `branch_d`=1, `rt_d`=3, `reg_write_e`=1, `write_reg_e`=3, `pc_src_d`=1 → `stall_d`=1, `flush_d`=0. Next cycle, hazard gone → `flush_d`=1, `flush_count` increments.
- **Memory wait.** `mem_req_m`=1, `mem_ready` low for 3 cycles then high → `stall_e`=`stall_m`=`flush_w`=1 for exactly 3 cycles, FSM back in IDLE, `mem_err`=0.
- **Timeout.** With `TIMEOUT`=4, hold `mem_ready` low → 4 stalled cycles, then `mem_err`=1 and stalls drop. Pulse `clr_n` low mid-sequence → `mem_err`=0 and counters 0 immediately.
- **Saturation.** With `CNT_W`=4, hold a load-use stall for 20 cycles → `stall_count`=15 and it stays at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, forwarding selects,
// data-memory wait tracking with timeout, and saturating event counters.
//
// state | meaning
// IDLE  | no outstanding memory wait; an unready request enters WAIT
// WAIT  | memory stage held; counting consecutive wait cycles
// ERR   | wait exceeded TIMEOUT; memory stalls released until reset
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       write_reg_e,
    input  logic [4:0]       write_reg_m,
    input  logic [4:0]       write_reg_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             mem_to_reg_e,
    input  logic             mem_to_reg_m,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic             pc_src_d,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    mem_state_t      state;
    logic [WC_W-1:0] wait_cnt;

    logic lw_stall;
    logic br_stall;
    logic mem_stall;

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        forward_a_e = 2'b00;
        if (reg_write_m && reg_match(write_reg_m, rs_e))
            forward_a_e = 2'b10;
        else if (reg_write_w && reg_match(write_reg_w, rs_e))
            forward_a_e = 2'b01;

        forward_b_e = 2'b00;
        if (reg_write_m && reg_match(write_reg_m, rt_e))
            forward_b_e = 2'b10;
        else if (reg_write_w && reg_match(write_reg_w, rt_e))
            forward_b_e = 2'b01;
    end

    assign forward_a_d = reg_write_m && reg_match(write_reg_m, rs_d);
    assign forward_b_d = reg_write_m && reg_match(write_reg_m, rt_d);

    assign lw_stall = mem_to_reg_e &&
                      (reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d));

    assign br_stall = branch_d &&
                      ((reg_write_e  && (reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d))) ||
                       (mem_to_reg_m && (reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d))));

    assign mem_stall = mem_req_m && !mem_ready && (state != ERR);

    assign stall_m = mem_stall;
    assign stall_e = mem_stall;
    assign flush_w = mem_stall;
    assign stall_f = lw_stall || br_stall || mem_stall;
    assign stall_d = stall_f;

    // A held execute register must not also be flushed, or the held instruction is lost.
    assign flush_e = (lw_stall || br_stall) && !mem_stall;
    assign flush_d = (pc_src_d || jump_d) && !stall_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_stall) begin
                        state    <= WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready || !mem_req_m) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_LAST) begin
                        // This edge ends the TIMEOUT-th stalled cycle.
                        state    <= ERR;
                        wait_cnt <= wait_cnt + WC_W'(1);
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                    mem_err  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_f && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if ((flush_d || flush_e) && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters.
module tb_hazard_ctrl;

    logic       clk;
    logic       clr_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m;
    logic       branch_d, jump_d, pc_src_d;
    logic       mem_req_m, mem_ready;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] forward_a_e, forward_b_e;
    logic       forward_a_d, forward_b_d;
    logic       mem_err;
    logic [3:0] stall_count, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .clr_n(clr_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
        .branch_d(branch_d), .jump_d(jump_d), .pc_src_d(pc_src_d),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem_to_reg_e = 0; mem_to_reg_m = 0;
        branch_d = 0; jump_d = 0; pc_src_d = 0;
        mem_req_m = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        #1;
    endtask

    initial begin
        clr_n = 1'b1;
        clear_inputs();
        #2;
        clr_n = 1'b0;
        #1;
        chk("rst_stall_f", stall_f, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_flush_count", flush_count, 0);
        chk("rst_fwd_a_e", forward_a_e, 0);
        step();
        clr_n = 1'b1;

        // Load-use
        step();
        mem_to_reg_e = 1; write_reg_e = 5; rs_d = 5;
        #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_e", flush_e, 1);
        chk("lu_stall_e", stall_e, 0);
        chk("lu_flush_d", flush_d, 0);
        step();
        chk("lu_stall_count", stall_count, 1);
        chk("lu_flush_count", flush_count, 1);
        write_reg_e = 0; rs_d = 0;
        #1;
        chk("lu_r0_stall_f", stall_f, 0);

        // Forwarding
        do_reset();
        rs_e = 7; write_reg_m = 7; write_reg_w = 7; reg_write_m = 1; reg_write_w = 1;
        #1;
        chk("fwd_a_mem_prio", forward_a_e, 2'b10);
        reg_write_m = 0;
        #1;
        chk("fwd_a_wb", forward_a_e, 2'b01);
        rs_e = 0; write_reg_m = 0; write_reg_w = 0; reg_write_m = 1;
        #1;
        chk("fwd_a_r0", forward_a_e, 2'b00);
        rt_e = 9; write_reg_m = 9; write_reg_w = 9;
        #1;
        chk("fwd_b_mem", forward_b_e, 2'b10);
        chk("fwd_a_other", forward_a_e, 2'b00);
        rs_d = 9; rt_d = 4;
        #1;
        chk("fwd_a_d", forward_a_d, 1);
        chk("fwd_b_d_nomatch", forward_b_d, 0);
        rs_d = 4; rt_d = 9;
        #1;
        chk("fwd_b_d", forward_b_d, 1);

        // Branch hazard and flush
        do_reset();
        branch_d = 1; rt_d = 3; reg_write_e = 1; write_reg_e = 3; pc_src_d = 1;
        #1;
        chk("br_stall_d", stall_d, 1);
        chk("br_flush_d", flush_d, 0);
        chk("br_flush_e", flush_e, 1);
        step();
        chk("br_stall_count", stall_count, 1);
        chk("br_flush_count1", flush_count, 1);
        reg_write_e = 0;
        #1;
        chk("br_gone_stall_d", stall_d, 0);
        chk("br_gone_flush_d", flush_d, 1);
        chk("br_gone_flush_e", flush_e, 0);
        step();
        chk("br_flush_count2", flush_count, 2);
        pc_src_d = 0; mem_to_reg_m = 1; write_reg_m = 3;
        #1;
        chk("br_load_m_stall", stall_d, 1);
        branch_d = 0;
        #1;
        chk("br_load_m_nobranch", stall_d, 0);

        // Memory wait with simultaneous load-use on the first cycle
        do_reset();
        mem_req_m = 1; mem_ready = 1;
        #1;
        chk("mem_ready_same", stall_e, 0);
        step();
        mem_ready = 0; mem_to_reg_e = 1; write_reg_e = 5; rs_d = 5;
        #1;
        chk("mw1_stall_m", stall_m, 1);
        chk("mw1_stall_e", stall_e, 1);
        chk("mw1_flush_w", flush_w, 1);
        chk("mw1_stall_f", stall_f, 1);
        chk("mw1_flush_e", flush_e, 0);
        step();
        mem_to_reg_e = 0; write_reg_e = 0; rs_d = 0;
        #1;
        chk("mw2_stall_e", stall_e, 1);
        step();
        chk("mw3_stall_m", stall_m, 1);
        step();
        mem_ready = 1;
        #1;
        chk("mw_done_stall_e", stall_e, 0);
        chk("mw_done_flush_w", flush_w, 0);
        step();
        chk("mw_mem_err", mem_err, 0);
        chk("mw_stall_count", stall_count, 3);

        // Timeout: fresh unready request must stall exactly 4 cycles
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_stall_%0d", i), stall_e, 1);
            chk($sformatf("to_noerr_%0d", i), mem_err, 0);
            step();
        end
        chk("to_mem_err", mem_err, 1);
        chk("to_released_e", stall_e, 0);
        chk("to_released_f", stall_f, 0);
        step();
        chk("to_err_sticky", mem_err, 1);

        // Asynchronous reset while in ERR
        clr_n = 1'b0;
        #1;
        chk("arst_mem_err", mem_err, 0);
        chk("arst_stall_count", stall_count, 0);
        chk("arst_flush_count", flush_count, 0);
        chk("arst_idle_stall", stall_e, 1);
        #1;
        clr_n = 1'b1;
        step();
        step();
        // Reset mid-WAIT, then the count restarts from 1
        clr_n = 1'b0;
        #1;
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rw_stall_%0d", i), stall_e, 1);
            chk($sformatf("rw_noerr_%0d", i), mem_err, 0);
            step();
        end
        chk("rw_mem_err", mem_err, 1);

        // Saturation
        do_reset();
        mem_to_reg_e = 1; write_reg_e = 5; rt_d = 5;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall_count", stall_count, 15);
        chk("sat_flush_count", flush_count, 15);
        step();
        chk("sat_stall_hold", stall_count, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
